// File: rtl/mem_wb_stage_if.sv
// Data-memory request/done bus between the memory-access stage and the data memory.
// The stage drives address, write data and level requests; the memory answers with a done pulse and read data.
interface mem_wb_stage_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_rd,
        output mem_wr,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_rd,
        input  mem_wr,
        output mem_rdata,
        output mem_done
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register: issues data-memory requests, stalls upstream
// while an access is outstanding, times out stuck accesses into a sticky error state.
module mem_wb_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic [15:0]    instruction,
    input  logic [15:0]    data_out,
    input  logic [15:0]    data_two,
    input  logic [2:0]     RD,
    input  logic           Reg_write,
    input  logic           Mem_read,
    input  logic           Mem_write,
    input  logic           Mem_reg,
    input  logic           Mem_en,
    mem_wb_stage_if.master mem,
    output logic           stall_o,
    output logic           valid_o,
    output logic [15:0]    instruction_o,
    output logic [15:0]    wb_data_o,
    output logic [2:0]     wb_reg_o,
    output logic           reg_write_o,
    output logic           err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        valid_reg;
    logic [15:0] instr_reg;
    logic [15:0] wb_data_reg;
    logic [2:0]  wb_reg_reg;
    logic        reg_write_reg;

    logic mem_op;
    logic illegal;
    logic in_err;
    logic stall;

    assign mem_op  = valid_in & Mem_en & (Mem_read | Mem_write);
    // Asking for a read and a write at once is a malformed control word, not a request.
    assign illegal = mem_op & Mem_read & Mem_write;
    assign in_err  = (state_reg == ERR);

    assign mem.mem_addr  = data_out;
    assign mem.mem_wdata = data_two;
    assign mem.mem_rd    = mem_op & Mem_read  & ~illegal & ~in_err;
    assign mem.mem_wr    = mem_op & Mem_write & ~illegal & ~in_err;

    // A done pulse in the request cycle itself lets the instruction through with no bubble.
    assign stall = (mem_op & ~mem.mem_done) | in_err | illegal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (illegal) begin
                    state_next = ERR;
                end else if (mem_op && !mem.mem_done) begin
                    state_next = WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT: begin
                // Done wins over the timeout when both land on the same edge.
                if (illegal) begin
                    state_next = ERR;
                end else if (mem.mem_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LIMIT) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg     <= 1'b0;
            instr_reg     <= '0;
            wb_data_reg   <= '0;
            wb_reg_reg    <= '0;
            reg_write_reg <= 1'b0;
        end else if (!stall) begin
            valid_reg     <= valid_in;
            instr_reg     <= instruction;
            wb_reg_reg    <= RD;
            reg_write_reg <= valid_in & Reg_write;
            wb_data_reg   <= Mem_reg ? mem.mem_rdata : data_out;
        end else begin
            // Bubble: only the qualifiers drop, payload registers keep their last value.
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
        end
    end

    assign stall_o       = stall;
    assign valid_o       = valid_reg;
    assign instruction_o = instr_reg;
    assign wb_data_o     = wb_data_reg;
    assign wb_reg_o      = wb_reg_reg;
    assign reg_write_o   = reg_write_reg;
    assign err_o         = in_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus randomized bench for mem_wb_stage against a cycle-level behavioural model.
module tb_mem_wb_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] instruction;
    logic [15:0] data_out;
    logic [15:0] data_two;
    logic [2:0]  RD;
    logic        Reg_write, Mem_read, Mem_write, Mem_reg, Mem_en;
    logic        stall_o, valid_o, reg_write_o, err_o;
    logic [15:0] instruction_o, wb_data_o;
    logic [2:0]  wb_reg_o;

    mem_wb_stage_if mem_bus();

    mem_wb_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instruction(instruction),
        .data_out(data_out), .data_two(data_two), .RD(RD), .Reg_write(Reg_write),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_reg(Mem_reg), .Mem_en(Mem_en),
        .mem(mem_bus), .stall_o(stall_o), .valid_o(valid_o), .instruction_o(instruction_o),
        .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o), .reg_write_o(reg_write_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: sticky error flag, count of request cycles spent on the current access, WB contents.
    bit          m_err   = 1'b0;
    int          m_n     = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_wb    = '0;
    logic [2:0]  m_reg   = '0;
    logic        m_rw    = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] dout,
                         input logic [15:0] dtwo, input logic [2:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic mreg, input logic men);
        valid_in = v; instruction = ins; data_out = dout; data_two = dtwo; RD = rd;
        Reg_write = rw; Mem_read = mr; Mem_write = mw; Mem_reg = mreg; Mem_en = men;
    endtask

    task automatic cycle(input logic done, input logic [15:0] rdata);
        logic mop, ill, stl;
        mem_bus.mem_done  = done;
        mem_bus.mem_rdata = rdata;
        #1;
        mop = valid_in & Mem_en & (Mem_read | Mem_write);
        ill = mop & Mem_read & Mem_write;
        stl = (mop & ~done) | m_err | ill;
        check("mem_addr", mem_bus.mem_addr, data_out);
        check("mem_wdata", mem_bus.mem_wdata, data_two);
        if (rst) begin
            check("mem_rd", {15'd0, mem_bus.mem_rd}, {15'd0, mop & Mem_read & ~ill & ~m_err});
            check("mem_wr", {15'd0, mem_bus.mem_wr}, {15'd0, mop & Mem_write & ~ill & ~m_err});
            check("stall_o", {15'd0, stall_o}, {15'd0, stl});
            check("err_pre", {15'd0, err_o}, {15'd0, m_err});
        end
        if (!rst) begin
            m_err = 1'b0; m_n = 0; m_valid = 1'b0; m_instr = '0; m_wb = '0; m_reg = '0; m_rw = 1'b0;
        end else begin
            if (!stl) begin
                m_valid = valid_in; m_instr = instruction; m_reg = RD;
                m_rw = valid_in & Reg_write; m_wb = Mem_reg ? rdata : data_out;
            end else begin
                m_valid = 1'b0; m_rw = 1'b0;
            end
            if (!m_err) begin
                if (ill) m_err = 1'b1;
                else if (mop) begin
                    if (done) m_n = 0;
                    else begin
                        m_n++;
                        if (m_n > TO) m_err = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid_o", {15'd0, valid_o}, {15'd0, m_valid});
        check("instruction_o", instruction_o, m_instr);
        check("wb_data_o", wb_data_o, m_wb);
        check("wb_reg_o", {13'd0, wb_reg_o}, {13'd0, m_reg});
        check("reg_write_o", {15'd0, reg_write_o}, {15'd0, m_rw});
        check("err_o", {15'd0, err_o}, {15'd0, m_err});
    endtask

    // Hold the current inputs for k request cycles with done on the last one.
    task automatic run_mem(input int k, input logic [15:0] rdata);
        for (int i = 1; i <= k; i++) begin
            if (i == k) cycle(1'b1, rdata);
            else cycle(1'b0, 16'($urandom));
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cycle(0, 0);
        cycle(0, 0);
        $display("[TB] reset: valid_o=%0d err_o=%0d", valid_o, err_o);
        rst = 1'b1;

        drive(1, 16'h1111, 16'h1234, 16'h0000, 3'd3, 1, 0, 0, 0, 0);
        cycle(0, 0);
        check("alu_wb", wb_data_o, 16'h1234);
        $display("[TB] alu op: wb=%h rd=%0d rw=%0d", wb_data_o, wb_reg_o, reg_write_o);

        drive(1, 16'h2222, 16'h0040, 16'h0000, 3'd1, 1, 1, 0, 1, 1);
        cycle(1, 16'hBEEF);
        check("zw_load_wb", wb_data_o, 16'hBEEF);
        $display("[TB] zero-wait load: wb=%h", wb_data_o);

        drive(1, 16'h3333, 16'h0044, 16'h0000, 3'd2, 1, 1, 0, 1, 1);
        run_mem(3, 16'hA5A5);
        check("load3_wb", wb_data_o, 16'hA5A5);
        $display("[TB] 3-cycle load: wb=%h valid=%0d", wb_data_o, valid_o);

        drive(1, 16'h4444, 16'h0050, 16'h00FF, 3'd4, 0, 0, 1, 0, 1);
        run_mem(2, 16'h0000);
        check("store_rw", {15'd0, reg_write_o}, 16'h0000);
        $display("[TB] store: wb=%h rw=%0d", wb_data_o, reg_write_o);

        drive(1, 16'h5555, 16'h0060, 16'h0000, 3'd5, 1, 1, 0, 1, 1);
        for (int i = 0; i < TO + 3; i++) cycle(0, 16'($urandom));
        check("timeout_err", {15'd0, err_o}, 16'h0001);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0);
        rst = 1'b1;
        check("timeout_clr", {15'd0, err_o}, 16'h0000);
        $display("[TB] timeout: err cleared by reset, err_o=%0d", err_o);

        drive(1, 16'h6666, 16'h0070, 16'h0000, 3'd6, 1, 1, 1, 0, 1);
        cycle(0, 0);
        check("illegal_err", {15'd0, err_o}, 16'h0001);
        $display("[TB] illegal op: err_o=%0d", err_o);
        rst = 1'b0;
        cycle(0, 0);
        rst = 1'b1;

        drive(1, 16'h7777, 16'h0080, 16'h0000, 3'd7, 1, 1, 0, 1, 1);
        cycle(0, 16'($urandom));
        cycle(0, 16'($urandom));
        rst = 1'b0;
        cycle(0, 16'($urandom));
        rst = 1'b1;
        check("midwait_rst", {15'd0, valid_o}, 16'h0000);
        run_mem(2, 16'h1357);
        check("post_rst_load", wb_data_o, 16'h1357);
        $display("[TB] reset mid-wait then load: wb=%h", wb_data_o);

        for (int t = 0; t < 40; t++) begin
            int kind, k;
            logic mreg;
            kind = $urandom_range(0, 2);
            k    = $urandom_range(1, TO + 1);
            mreg = 1'($urandom);
            drive(0, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle(1'($urandom), 16'($urandom));
            case (kind)
                0: begin
                    drive(1, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), mreg, 0);
                    cycle(1'($urandom), 16'($urandom));
                end
                1: begin
                    drive(1, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                          1, 0, mreg, 1);
                    run_mem(k, 16'($urandom));
                end
                default: begin
                    drive(1, 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                          0, 1, 0, 1);
                    run_mem(k, 16'($urandom));
                end
            endcase
            $display("[TB] rand txn %0d kind=%0d k=%0d wb=%h valid=%0d", t, kind, k, wb_data_o, valid_o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
